sdram_burst_read: RTL and testbench

//  Parametrised SDRAM read engine: on a start request, reads app_bursts bursts of BURST_LEN DQ words from

---
 rtl/sdram_burst_read_pkg.sv | 25 ++
 rtl/sdram_read_packer.sv | 62 ++++++
 rtl/sdram_burst_read.sv | 155 +++++++++++++++
 tb/tb_sdram_burst_read.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_burst_read_pkg.sv
// Shared SDRAM command codes, timing defaults and FSM state type for the burst read engine.
package sdram_burst_read_pkg;

  // {ras_n, cas_n, we_n} command encodings
  localparam logic [2:0] SDRAM_CMD_NOP  = 3'b111;
  localparam logic [2:0] SDRAM_CMD_ACT  = 3'b011;
  localparam logic [2:0] SDRAM_CMD_READ = 3'b101;

  localparam int DEF_CAS_LAT   = 2;
  localparam int DEF_T_RCD     = 2;
  localparam int DEF_T_RP      = 2;
  localparam int DEF_BURST_LEN = 2;

  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_OK,
    ST_ACTIVATE,
    ST_READ_CMD,
    ST_DRAIN,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/sdram_read_packer.sv
// Packs consecutive DQ words MSB-first into FIFO words; pushes one cycle after the last word of a group.
module sdram_read_packer #(
  parameter int DQ_W   = 16,
  parameter int FIFO_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DQ_W-1:0]   data_i,
  output logic [FIFO_W-1:0] fifo_data_o,
  output logic              fifo_write_o
);

  localparam int PACK = FIFO_W / DQ_W;

  logic [FIFO_W-1:0] fifo_data_q;
  logic              fifo_write_q;

  generate
    if (PACK == 1) begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_data_q  <= '0;
          fifo_write_q <= 1'b0;
        end else begin
          fifo_write_q <= valid_i;
          if (valid_i) fifo_data_q <= data_i;
        end
      end
    end else begin : g_pack
      localparam int CW = $clog2(PACK);
      logic [CW-1:0]          cnt_q;
      logic [FIFO_W-DQ_W-1:0] acc_q;

      // acc_q keeps the earlier words of the group; older words end up in the upper bits
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q        <= '0;
          acc_q        <= '0;
          fifo_data_q  <= '0;
          fifo_write_q <= 1'b0;
        end else begin
          fifo_write_q <= 1'b0;
          if (valid_i) begin
            if (cnt_q == CW'(PACK - 1)) begin
              cnt_q        <= '0;
              fifo_data_q  <= {acc_q, data_i};
              fifo_write_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              acc_q <= (FIFO_W-DQ_W)'({acc_q, data_i});
            end
          end
        end
      end
    end
  endgenerate

  assign fifo_data_o  = fifo_data_q;
  assign fifo_write_o = fifo_write_q;

endmodule

// File: rtl/sdram_burst_read.sv
// SDRAM burst read engine: ACT + READ(auto-precharge) per burst, CAS-aligned capture, packed FIFO pushes.
module sdram_burst_read
  import sdram_burst_read_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int FIFO_W    = 32,
  parameter int ROW_W     = 12,
  parameter int COL_W     = 8,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CAS_LAT   = DEF_CAS_LAT,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [2:0]               command,
  output logic [ROW_W-1:0]         address,
  output logic [1:0]               bank,
  input  logic [DQ_W-1:0]          data_in,
  input  logic                     start,
  input  logic [2+ROW_W+COL_W-1:0] app_address,
  input  logic [15:0]              app_bursts,
  input  logic                     auto_refresh,
  output logic                     idle,
  output logic                     done,
  output logic [FIFO_W-1:0]        fifo_data,
  output logic                     fifo_write,
  input  logic                     fifo_ready
);

  localparam int AW     = 2 + ROW_W + COL_W;
  localparam int PIPE_W = CAS_LAT + BURST_LEN;
  localparam int DLY_W  = 8;

  state_t           state_q;
  logic [2:0]       command_q;
  logic [ROW_W-1:0] address_q;
  logic [1:0]       bank_q;
  logic             done_q;
  logic [DLY_W-1:0] delay_q;
  logic [AW-1:0]    addr_q;
  logic [15:0]      count_q;
  logic [PIPE_W-1:0] pipe_q;

  logic [1:0]       cur_bank;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] rd_addr;
  logic             issue_read;
  logic             capture;

  assign cur_bank = addr_q[AW-1 -: 2];
  assign cur_row  = addr_q[COL_W +: ROW_W];
  assign cur_col  = addr_q[COL_W-1:0];

  always_comb begin
    rd_addr            = '0;
    rd_addr[COL_W-1:0] = cur_col;
    rd_addr[A10_BIT]   = 1'b1;
  end

  assign issue_read = (state_q == ST_ACTIVATE) && (delay_q == '0);

  // pipe_q[i] set means a READ went onto the bus i cycles ago
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= {pipe_q[PIPE_W-2:0], issue_read};
  end

  assign capture = |pipe_q[CAS_LAT +: BURST_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      command_q <= SDRAM_CMD_NOP;
      address_q <= '0;
      bank_q    <= '0;
      done_q    <= 1'b0;
      delay_q   <= '0;
      addr_q    <= '0;
      count_q   <= '0;
    end else begin
      command_q <= SDRAM_CMD_NOP;
      done_q    <= 1'b0;
      if (delay_q != '0) delay_q <= delay_q - DLY_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (app_bursts == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= app_address;
              count_q <= app_bursts;
              state_q <= ST_WAIT_OK;
            end
          end
        end
        ST_WAIT_OK: begin
          if ((delay_q == '0) && !auto_refresh && fifo_ready) begin
            command_q <= SDRAM_CMD_ACT;
            bank_q    <= cur_bank;
            address_q <= cur_row;
            delay_q   <= DLY_W'(T_RCD - 1);
            state_q   <= ST_ACTIVATE;
          end
        end
        ST_ACTIVATE: begin
          if (issue_read) begin
            command_q <= SDRAM_CMD_READ;
            address_q <= rd_addr;
            state_q   <= ST_READ_CMD;
          end
        end
        ST_READ_CMD: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          // last word of the burst is being captured this cycle
          if (pipe_q[PIPE_W-1]) begin
            addr_q  <= addr_q + AW'(BURST_LEN);
            count_q <= count_q - 16'd1;
            delay_q <= DLY_W'(T_RP);
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (count_q == 16'd0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_OK;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sdram_read_packer #(
    .DQ_W   (DQ_W),
    .FIFO_W (FIFO_W)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (capture),
    .data_i       (data_in),
    .fifo_data_o  (fifo_data),
    .fifo_write_o (fifo_write)
  );

  assign command = command_q;
  assign address = address_q;
  assign bank    = bank_q;
  assign done    = done_q;
  assign idle    = ((state_q == ST_IDLE) || (state_q == ST_WAIT_OK)) && (delay_q == '0) && (pipe_q == '0);

endmodule

// File: tb/tb_sdram_burst_read.sv
// Bench for sdram_burst_read: SDRAM read model plus command/word scoreboards, two burst lengths.
module tb_sdram_burst_read;
  import sdram_burst_read_pkg::*;

  localparam int CL   = 2;
  localparam int T_RP = 2;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cmd_w   [2];
  logic [11:0] addr_w  [2];
  logic [1:0]  bank_w  [2];
  logic [15:0] dq_v    [2];
  logic        start_v [2];
  logic        idle_w  [2];
  logic        done_w  [2];
  logic        fw_w    [2];
  logic [31:0] fd_w    [2];
  logic [21:0] app_address;
  logic [15:0] app_bursts;
  logic        auto_refresh;
  logic        fifo_ready;

  sdram_burst_read #(.BURST_LEN(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .command(cmd_w[0]), .address(addr_w[0]), .bank(bank_w[0]),
    .data_in(dq_v[0]), .start(start_v[0]), .app_address(app_address), .app_bursts(app_bursts),
    .auto_refresh(auto_refresh), .idle(idle_w[0]), .done(done_w[0]), .fifo_data(fd_w[0]),
    .fifo_write(fw_w[0]), .fifo_ready(fifo_ready)
  );

  sdram_burst_read #(.BURST_LEN(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .command(cmd_w[1]), .address(addr_w[1]), .bank(bank_w[1]),
    .data_in(dq_v[1]), .start(start_v[1]), .app_address(app_address), .app_bursts(app_bursts),
    .auto_refresh(auto_refresh), .idle(idle_w[1]), .done(done_w[1]), .fifo_data(fd_w[1]),
    .fifo_write(fw_w[1]), .fifo_ready(fifo_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks, n_fail, cyc;
  int push_cnt, done_cnt, act_cnt, read_cnt, nonnop_cnt;
  int last_push_cyc, done_cyc, last_act_cyc, start_cyc, p0, d0;
  int last_data_cyc [2];
  logic        first_seen;
  logic [31:0] first_word;
  logic [11:0] open_row [2][4];
  logic [15:0] sched [int];
  logic [17:0] exp_cmds [$];
  logic [32:0] exp_words [$];

  typedef struct {
    int          unit;
    logic [21:0] addr;
    int          bursts;
    int          pushes;
    logic [31:0] first;   // 0: take first word from the data model
  } vec_t;
  vec_t vecs [5];

  function automatic int bl_of(int u);
    return (u == 0) ? 2 : 8;
  endfunction

  function automatic logic [15:0] word_at(logic [21:0] a);
    logic [21:0] m;
    if (a == 22'h012345) return 16'hA1B2;
    if (a == 22'h012346) return 16'hC3D4;
    m = a * 22'd40503;
    return m[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: advance to the falling edge, then model the SDRAM and score the outputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int u = 0; u < 2; u++) begin
      int          key;
      logic [17:0] e;
      logic [32:0] w;
      logic [7:0]  c;
      key = u * 1000000 + cyc;
      if (cmd_w[u] !== SDRAM_CMD_NOP) begin
        nonnop_cnt++;
        check("cmd_expected", 64'(exp_cmds.size() != 0), 64'd1);
        if (exp_cmds.size() != 0) begin
          e = exp_cmds.pop_front();
          check("cmd", {u[0], cmd_w[u], bank_w[u], addr_w[u]}, e);
        end
        if (cmd_w[u] == SDRAM_CMD_ACT) begin
          act_cnt++;
          last_act_cyc = cyc;
          open_row[u][bank_w[u]] = addr_w[u];
          if (last_data_cyc[u] > 0) check("act_trp_gap", 64'((cyc - last_data_cyc[u]) > T_RP), 64'd1);
        end else if (cmd_w[u] == SDRAM_CMD_READ) begin
          read_cnt++;
          for (int k = 0; k < bl_of(u); k++) begin
            c = addr_w[u][7:0] + 8'(k);
            sched[u * 1000000 + cyc + CL + k] = word_at({bank_w[u], open_row[u][bank_w[u]], c});
          end
        end
      end
      if (sched.exists(key)) begin
        dq_v[u] = sched[key];
        sched.delete(key);
        last_data_cyc[u] = cyc;
      end else begin
        dq_v[u] = 16'h0BAD;
      end
      if (fw_w[u] === 1'b1) begin
        push_cnt++;
        last_push_cyc = cyc;
        if (!first_seen) first_word = fd_w[u];
        first_seen = 1'b1;
        check("push_expected", 64'(exp_words.size() != 0), 64'd1);
        if (exp_words.size() != 0) begin
          w = exp_words.pop_front();
          check("fifo_data", {u[0], fd_w[u]}, w);
        end
      end
      if (done_w[u] === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic expect_txn(int u, logic [21:0] a0, int n);
    logic [21:0] a;
    for (int b = 0; b < n; b++) begin
      a = a0 + 22'(b * bl_of(u));
      exp_cmds.push_back({u[0], SDRAM_CMD_ACT, a[21:20], a[19:8]});
      exp_cmds.push_back({u[0], SDRAM_CMD_READ, a[21:20], 4'h4, a[7:0]});
      for (int p = 0; p < bl_of(u) / 2; p++)
        exp_words.push_back({u[0], word_at(a + 22'(2 * p)), word_at(a + 22'(2 * p + 1))});
    end
  endtask

  task automatic start_txn(int u, logic [21:0] a, int n);
    p0 = push_cnt;
    d0 = done_cnt;
    first_seen = 1'b0;
    expect_txn(u, a, n);
    app_address = a;
    app_bursts  = 16'(n);
    start_v[u]  = 1'b1;
    start_cyc   = cyc;
    tick();
    start_v[u]  = 1'b0;
  endtask

  task automatic wait_done(string name, int exp_pushes);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 3000) begin
      tick();
      g++;
    end
    check({name, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_pushes"}, 64'(push_cnt - p0), 64'(exp_pushes));
    if (exp_pushes > 0) check({name, "_done_after_push"}, 64'(done_cyc), 64'(last_push_cyc + 1));
    else                check({name, "_done_latency"}, 64'(done_cyc), 64'(start_cyc + 1));
    check({name, "_cmds_left"}, 64'(exp_cmds.size()), 64'd0);
    check({name, "_words_left"}, 64'(exp_words.size()), 64'd0);
    $display("txn %s: addr=%06h bursts=%0d pushes=%0d done@%0d", name, app_address, app_bursts,
             push_cnt - p0, done_cyc);
    g = 0;
    while (!(idle_w[0] && idle_w[1]) && g < 100) begin
      tick();
      g++;
    end
    check({name, "_idle_after"}, 64'(idle_w[0] && idle_w[1]), 64'd1);
  endtask

  initial begin
    int g, a0, n0, pb, dd;
    logic [31:0] fexp;
    n_checks = 0; n_fail = 0; cyc = 0;
    push_cnt = 0; done_cnt = 0; act_cnt = 0; read_cnt = 0; nonnop_cnt = 0;
    last_push_cyc = 0; done_cyc = 0; last_act_cyc = 0; start_cyc = 0; p0 = 0; d0 = 0;
    last_data_cyc[0] = 0; last_data_cyc[1] = 0;
    first_seen = 1'b0; first_word = '0;
    rst_n = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    dq_v[0] = '0; dq_v[1] = '0;
    app_address = '0; app_bursts = '0;
    auto_refresh = 1'b0; fifo_ready = 1'b1;

    vecs[0] = '{0, 22'h012345, 1, 1, 32'hA1B2C3D4};
    vecs[1] = '{1, 22'h000010, 3, 12, 32'h0};
    vecs[2] = '{0, 22'h0123FE, 2, 2, 32'h0};
    vecs[3] = '{0, 22'h3FFFFE, 2, 2, 32'h0};
    vecs[4] = '{1, 22'h2ABCF8, 2, 8, 32'h0};

    tick();
    tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_command", 64'(cmd_w[u]), 64'(SDRAM_CMD_NOP));
      check("rst_address", 64'(addr_w[u]), 64'd0);
      check("rst_bank", 64'(bank_w[u]), 64'd0);
      check("rst_fifo_data", 64'(fd_w[u]), 64'd0);
      check("rst_fifo_write", 64'(fw_w[u]), 64'd0);
      check("rst_done", 64'(done_w[u]), 64'd0);
      check("rst_idle", 64'(idle_w[u]), 64'd1);
    end
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 5; i++) begin
      start_txn(vecs[i].unit, vecs[i].addr, vecs[i].bursts);
      wait_done($sformatf("vec%0d", i), vecs[i].pushes);
      fexp = (vecs[i].first != 32'h0) ? vecs[i].first
           : {word_at(vecs[i].addr), word_at(vecs[i].addr + 22'd1)};
      check($sformatf("vec%0d_first_word", i), 64'(first_word), 64'(fexp));
    end

    // fifo_ready low before the first ACT
    fifo_ready = 1'b0;
    a0 = act_cnt;
    n0 = nonnop_cnt;
    start_txn(0, 22'h000200, 1);
    repeat (20) tick();
    check("fr_no_cmd", 64'(nonnop_cnt), 64'(n0));
    check("fr_idle", 64'(idle_w[0]), 64'd1);
    fifo_ready = 1'b1;
    tick();
    check("fr_act_count", 64'(act_cnt), 64'(a0 + 1));
    check("fr_act_next_cycle", 64'(last_act_cyc), 64'(cyc));
    wait_done("fifo_ready_hold", 1);

    // refresh held between two bursts
    start_txn(0, 22'h000300, 2);
    g = 0;
    while (push_cnt == p0 && g < 200) begin
      tick();
      g++;
    end
    auto_refresh = 1'b1;
    a0 = act_cnt;
    n0 = nonnop_cnt;
    repeat (20) tick();
    check("ref_no_cmd", 64'(nonnop_cnt), 64'(n0));
    check("ref_idle", 64'(idle_w[0]), 64'd1);
    auto_refresh = 1'b0;
    tick();
    check("ref_act_count", 64'(act_cnt), 64'(a0 + 1));
    check("ref_act_next_cycle", 64'(last_act_cyc), 64'(cyc));
    wait_done("refresh_hold", 2);

    // refresh raised mid-burst must not cut the data short
    a0 = act_cnt;
    start_txn(0, 22'h000100, 1);
    g = 0;
    while (act_cnt == a0 && g < 100) begin
      tick();
      g++;
    end
    auto_refresh = 1'b1;
    wait_done("refresh_mid_burst", 1);
    auto_refresh = 1'b0;

    // zero bursts: immediate done, no SDRAM traffic
    n0 = nonnop_cnt;
    start_txn(0, 22'h001234, 0);
    wait_done("zero_bursts", 0);
    check("zero_no_cmd", 64'(nonnop_cnt), 64'(n0));

    // second start while busy is ignored
    start_txn(0, 22'h000500, 2);
    repeat (3) tick();
    app_address = 22'h003000;
    app_bursts  = 16'd5;
    start_v[0]  = 1'b1;
    tick();
    start_v[0]  = 1'b0;
    wait_done("start_while_busy", 2);
    dd = done_cnt;
    n0 = nonnop_cnt;
    repeat (30) tick();
    check("busy_no_extra_done", 64'(done_cnt), 64'(dd));
    check("busy_no_extra_cmd", 64'(nonnop_cnt), 64'(n0));

    // asynchronous reset during DRAIN
    g = read_cnt;
    start_txn(0, 22'h000700, 1);
    dd = 0;
    while (read_cnt == g && dd < 100) begin
      tick();
      dd++;
    end
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_command", 64'(cmd_w[0]), 64'(SDRAM_CMD_NOP));
    check("arst_fifo_write", 64'(fw_w[0]), 64'd0);
    check("arst_idle", 64'(idle_w[0]), 64'd1);
    check("arst_cmds_left", 64'(exp_cmds.size()), 64'd0);
    exp_words.delete();
    pb = push_cnt;
    dd = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("arst_no_stale_push", 64'(push_cnt), 64'(pb));
    check("arst_no_done", 64'(done_cnt), 64'(dd));
    check("arst_idle_after", 64'(idle_w[0]), 64'd1);
    $display("txn reset_in_drain: pushes after release=%0d", push_cnt - pb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
